io_event_monitor: RTL and testbench
===================================

Name: io_event_monitor

Overview:
Parametrised successor to the board-level LED watcher and cycle-budget logic, implemented as synthesizable RTL.
- Watches a WIDTH-bit status bus (LEDs/GPIO) and timestamps every value change into a FIFO, drained through a valid/ready port.
- Generates a heartbeat pulse every HEARTBEAT cycles and declares a run complete after RUN_BEATS beats.
- Sits beside the SoC top: usable in silicon (debug UART feeder) and in simulation benches.

Parameters:
WIDTH, 8, width of monitored bus
DEPTH, 16, event FIFO entries (power of 2, >=2)
TS_WIDTH, 32, timestamp counter width
HEARTBEAT, 50000, cycles per heartbeat (>=2)
RUN_BEATS, 6, beats until done; 0 = never done
SETTLE, 4, stability cycles required when settle feature is enabled (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
enable  in  1  start/continue monitoring
in_data  in  WIDTH  monitored bus (assumed synchronous to clk)
ev_valid  out  1  FIFO head valid
ev_ready  in  1  consumer accepts head
ev_data  out  WIDTH  head event value
ev_time  out  TS_WIDTH  head event timestamp
overflow  out  1  sticky: at least one event dropped
beat  out  1  one-cycle heartbeat pulse
done  out  1  run complete (level)

Behaviour:
Reset values:
- All outputs 0; FIFO empty.
- Timestamp = 0, prev = 0, in_q = 0, beat counter = 0, state IDLE.

State machine (IDLE, RUN, DONE):
- IDLE -> RUN when enable=1.
- RUN -> IDLE when enable=0. Counters hold; they are not cleared.
- RUN -> DONE on the RUN_BEATS-th beat (never if RUN_BEATS=0).
- DONE is terminal until reset.

Timestamp:
- Increments every cycle in RUN; holds in IDLE/DONE.
- Wraps modulo 2^TS_WIDTH with no flag.

Heartbeat:
- Cycle counter runs only in RUN and wraps at HEARTBEAT-1.
- beat=1 for the cycle after the wrap edge.
- The first beat occurs HEARTBEAT RUN cycles after entering RUN.

Change detect:
- in_data is registered into in_q.
- In RUN, if in_q != prev: push {in_q, timestamp}, then prev <= in_q.
- Latency: a value present before edge N gives ev_valid=1 after edge N+1 (FIFO empty). ev_time equals the timestamp value at edge N.
- prev resets to 0, so a nonzero initial input yields an event.
- A change that is present before enable rises is detected on the first RUN cycle.

Recording gates:
- No pushes in IDLE or DONE.
- Popping continues in every state.

FIFO and handshake:
- Pop occurs when ev_valid && ev_ready.
- ev_data/ev_time are stable while ev_valid=1 and ev_ready=0.
- Full without pop: the event is dropped, overflow set, and prev still updates.
- Full with a simultaneous pop: the push is accepted.
- Empty with a push: no same-cycle bypass.
- overflow clears only on reset.

Reset mid-operation: discards FIFO contents, clears done/overflow, returns to IDLE.

Optional Feature:
MONITOR_SETTLE_EN.
- Defined: a candidate value must equal in_q for SETTLE consecutive RUN cycles before it is pushed. ev_time is the timestamp of the first cycle of the stable window. Glitches shorter than SETTLE produce no event. Latency grows by SETTLE-1 cycles.
- Undefined: every single-cycle change is recorded. The SETTLE parameter is ignored.

Decomposition:
Shared package io_monitor_pkg holds:
- state enum (IDLE/RUN/DONE)
- event struct {value, time}
- localparam for FIFO pointer width, $clog2(DEPTH)

One sub-module: io_event_fifo.
- Synchronous FIFO, DEPTH x (WIDTH+TS_WIDTH).
- Pointers with extra wrap bit.
- Exposes push/pop/full/empty.

Test Plan:
1. Reset, enable=1, in_data=0x01 at cycle 3 -> one event {0x01, ts=3 rel. to RUN start}; ev_valid after 2 edges; no further events.
2. HEARTBEAT=10, RUN_BEATS=3, enable held -> beat pulses at RUN cycles 10/20/30; done=1 after third beat; later in_data changes produce no events.
3. DEPTH=4, ev_ready=0, 6 distinct changes -> 4 events stored in order, overflow=1; drain yields first 4 values with increasing ev_time.
4. FIFO full; change coincides with ev_ready=1 -> pop and push same cycle; count stays 4; overflow remains 0.
5. enable deasserted for 5 cycles mid-run -> timestamp and beat counter frozen; ev_time gap excludes those cycles; resumes on enable.
6. MONITOR_SETTLE_EN, SETTLE=4: 2-cycle glitch 0x00->0xFF->0x00 -> no event; 0xAA held 4 cycles -> one event {0xAA, first stable ts}.

Source files
------------

// File: rtl/io_monitor_pkg.sv
// Shared types and defaults for the I/O event monitor.
// Holds the run-state enum, the default event record layout and the
// default FIFO pointer width used by io_event_fifo and io_event_monitor.
package io_monitor_pkg;

   // Run state of the monitor; DONE is left only through reset.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Default configuration of the monitor.
   localparam int unsigned DEF_WIDTH    = 8;
   localparam int unsigned DEF_TS_WIDTH = 32;
   localparam int unsigned DEF_DEPTH    = 16;

   // FIFO pointer width (index bits, without the extra wrap bit).
   localparam int unsigned EV_PTR_W = $clog2(DEF_DEPTH);

   // One recorded event at the default widths: value seen and when.
   typedef struct packed {
      logic [DEF_WIDTH-1:0]    value;
      logic [DEF_TS_WIDTH-1:0] tstamp;
   } event_t;

endpackage

// File: rtl/io_event_fifo.sv
// Synchronous event FIFO, DEPTH entries of DW bits.
// Read/write pointers carry one extra wrap bit to tell full from empty.
// A push while full is accepted only if a pop happens in the same cycle.
module io_event_fifo
   import io_monitor_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned PTR_W = EV_PTR_W,
   parameter int unsigned DW    = DEF_WIDTH + DEF_TS_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] head_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic           do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || pop_i);
   assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   // Next pointer values from the accepted push/pop.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
   end

   // Pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/io_event_monitor.sv
// Status-bus event monitor with heartbeat and run budget.
// Registers in_data, timestamps every change seen while running into a
// FIFO drained via ev_valid/ev_ready, pulses beat every HEARTBEAT running
// cycles and goes DONE after RUN_BEATS beats (never when RUN_BEATS = 0).
// Optional macro MONITOR_SETTLE_EN: a value must be stable for SETTLE
// consecutive running cycles before it is recorded.
module io_event_monitor
   import io_monitor_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned TS_WIDTH  = DEF_TS_WIDTH,
   parameter int unsigned HEARTBEAT = 50000,
   parameter int unsigned RUN_BEATS = 6,
   parameter int unsigned SETTLE    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [WIDTH-1:0]    in_data,
   output logic                ev_valid,
   input  logic                ev_ready,
   output logic [WIDTH-1:0]    ev_data,
   output logic [TS_WIDTH-1:0] ev_time,
   output logic                overflow,
   output logic                beat,
   output logic                done
);

   localparam int unsigned CYC_W  = $clog2(HEARTBEAT);
   localparam int unsigned BEAT_W = $clog2(RUN_BEATS + 2);
   localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(HEARTBEAT - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RUN_BEATS - 1);

   // Reject configurations the counters cannot represent.
   if (HEARTBEAT < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SETTLE < 1) begin : g_bad_cfg
      $error("io_event_monitor: illegal HEARTBEAT/DEPTH/SETTLE");
   end

   typedef struct packed {
      logic [WIDTH-1:0]    value;
      logic [TS_WIDTH-1:0] tstamp;
   } ev_t;

   state_e              state_q, state_d;
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [CYC_W-1:0]    cyc_q, cyc_d;
   logic [BEAT_W-1:0]   beats_q, beats_d;
   logic                beat_q;
   logic [WIDTH-1:0]    in_q, prev_q, prev_d;
   logic                overflow_q, overflow_d;
   logic                running, wrap, last_beat;
   logic                push_req, pop, fifo_full, fifo_empty;
   logic [TS_WIDTH-1:0] push_ts;
   ev_t                 push_rec, head_rec;

   assign running   = (state_q == RUN);
   assign wrap      = running && (cyc_q == CYC_LAST);
   assign last_beat = (RUN_BEATS != 0) && wrap && (beats_q == BEAT_LAST);

`ifdef MONITOR_SETTLE_EN
   localparam int unsigned SET_W = $clog2(SETTLE + 1);

   logic [WIDTH-1:0]    cand_q, cand_d;
   logic [SET_W-1:0]    cnt_q, cnt_d;
   logic [TS_WIDTH-1:0] cand_ts_q, cand_ts_d;
   logic                same;

   // Track how long the current value has been stable; push once it reaches SETTLE.
   always_comb begin
      same      = (in_q == cand_q);
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      cand_ts_d = cand_ts_q;
      if (running) begin
         if (!same) begin
            cand_d    = in_q;
            cnt_d     = SET_W'(1);
            cand_ts_d = ts_q;
         end else if (cnt_q != SET_W'(SETTLE)) begin
            cnt_d = cnt_q + SET_W'(1);
         end
      end
      push_ts  = same ? cand_ts_q : ts_q;
      push_req = running && (in_q != prev_q) && (cnt_d == SET_W'(SETTLE));
   end

   // Stability-window registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cand_q    <= '0;
         cnt_q     <= '0;
         cand_ts_q <= '0;
      end else begin
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         cand_ts_q <= cand_ts_d;
      end
   end
`else
   assign push_req = running && (in_q != prev_q);
   assign push_ts  = ts_q;
`endif

   assign pop             = ev_valid && ev_ready;
   assign push_rec.value  = in_q;
   assign push_rec.tstamp = push_ts;

   // Run-state transitions; reaching the beat budget beats a simultaneous enable drop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN: begin
            if (last_beat)    state_d = DONE;
            else if (!enable) state_d = IDLE;
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Timestamp, heartbeat, change history and overflow next-state.
   always_comb begin
      ts_d       = ts_q;
      cyc_d      = cyc_q;
      beats_d    = beats_q;
      prev_d     = push_req ? in_q : prev_q;
      overflow_d = overflow_q || (push_req && fifo_full && !pop);
      if (running) begin
         ts_d  = ts_q + TS_WIDTH'(1);
         cyc_d = wrap ? '0 : cyc_q + CYC_W'(1);
         if (wrap) beats_d = beats_q + BEAT_W'(1);
      end
   end

   // Monitor state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         cyc_q      <= '0;
         beats_q    <= '0;
         beat_q     <= 1'b0;
         in_q       <= '0;
         prev_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         cyc_q      <= cyc_d;
         beats_q    <= beats_d;
         beat_q     <= wrap;
         in_q       <= in_data;
         prev_q     <= prev_d;
         overflow_q <= overflow_d;
      end
   end

   io_event_fifo #(
      .DEPTH (DEPTH),
      .PTR_W ($clog2(DEPTH)),
      .DW    ($bits(ev_t))
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push_req),
      .push_data_i (push_rec),
      .pop_i       (pop),
      .head_o      (head_rec),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Head fields read as zero while the FIFO is empty.
   assign ev_valid = !fifo_empty;
   assign ev_data  = ev_valid ? head_rec.value  : '0;
   assign ev_time  = ev_valid ? head_rec.tstamp : '0;
   assign overflow = overflow_q;
   assign beat     = beat_q;
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_io_event_monitor.sv
// Self-checking bench for io_event_monitor (DEPTH=4, HEARTBEAT=10, RUN_BEATS=3).
// A cycle-level reference model built from the behavioural rules (run-cycle
// count, event queue, sample history) predicts every output after each edge;
// directed scenarios add hand-computed expectations.
module tb_io_event_monitor;

   localparam int W   = 8;
   localparam int D   = 4;
   localparam int TSW = 16;
   localparam int HB  = 10;
   localparam int RB  = 3;
   localparam int ST  = 4;
`ifdef MONITOR_SETTLE_EN
   localparam int SETTLE_EFF = ST;
`else
   localparam int SETTLE_EFF = 1;
`endif
   localparam int unsigned TS_MOD = 1 << TSW;
   localparam int MODE_IDLE = 0;
   localparam int MODE_RUN  = 1;
   localparam int MODE_DONE = 2;

   logic           clk = 1'b0;
   logic           reset, enable, ev_ready;
   logic [W-1:0]   in_data;
   logic           ev_valid, overflow, beat, done;
   logic [W-1:0]   ev_data;
   logic [TSW-1:0] ev_time;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_event_monitor #(
      .WIDTH(W), .DEPTH(D), .TS_WIDTH(TSW), .HEARTBEAT(HB), .RUN_BEATS(RB), .SETTLE(ST)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .ev_time(ev_time),
      .overflow(overflow), .beat(beat), .done(done)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned value;
      int unsigned ts;
   } rec_t;

   rec_t        mq[$];
   int unsigned s_val[$];
   int unsigned s_ts[$];
   int unsigned m_runc = 0;
   int          m_mode = MODE_IDLE;
   int unsigned m_inq = 0, m_prev = 0;
   bit          m_ovf = 0, m_beat = 0;

   task automatic model_edge(input bit rst, input bit en, input logic [W-1:0] din, input bit rdy);
      bit          pop, do_push;
      int          sz, len;
      int unsigned ts, start_ts;
      rec_t        rec;
      pop = 0;
      do_push = 0;
      rec = '{0, 0};
      if (rst) begin
         mq.delete(); s_val.delete(); s_ts.delete();
         m_runc = 0; m_mode = MODE_IDLE; m_inq = 0; m_prev = 0; m_ovf = 0; m_beat = 0;
         return;
      end
      sz = mq.size();
      pop = (sz > 0) && rdy;
      m_beat = 0;
      if (m_mode == MODE_RUN) begin
         ts = m_runc % TS_MOD;
         s_val.push_back(m_inq);
         s_ts.push_back(ts);
         len = 0;
         start_ts = ts;
         for (int i = s_val.size() - 1; i >= 0 && s_val[i] == m_inq; i--) begin
            len++;
            start_ts = s_ts[i];
         end
         if (len >= SETTLE_EFF && m_inq != m_prev) begin
            m_prev = m_inq;
            if (sz < D || pop) begin
               do_push = 1;
               rec.value = m_inq;
               rec.ts = start_ts;
            end else begin
               m_ovf = 1;
            end
         end
         m_runc++;
         if (m_runc % HB == 0) m_beat = 1;
         if (RB != 0 && m_runc == HB * RB) m_mode = MODE_DONE;
         else if (!en) m_mode = MODE_IDLE;
      end else if (m_mode == MODE_IDLE && en) begin
         m_mode = MODE_RUN;
      end
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(rec);
      m_inq = din;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("ev_valid", ev_valid, mq.size() > 0);
      check("ev_data",  ev_data,  mq.size() > 0 ? mq[0].value : 0);
      check("ev_time",  ev_time,  mq.size() > 0 ? mq[0].ts : 0);
      check("overflow", overflow, m_ovf);
      check("beat",     beat,     m_beat);
      check("done",     done,     m_mode == MODE_DONE);
   endtask

   // Drive inputs, take one edge, advance the model, compare 1 time unit later.
   task automatic step(input bit rst, input bit en, input logic [W-1:0] din, input bit rdy);
      reset = rst;
      enable = en;
      in_data = din;
      ev_ready = rdy;
      @(posedge clk);
      model_edge(rst, en, din, rdy);
      #1;
      compare_all();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] cur;
      logic [W-1:0] pick [5];
      int           n;
      int           first_done;
      int           beat_edges[$];
      int unsigned  seen_val[$];
      int unsigned  seen_ts[$];
      pick = '{8'h00, 8'h01, 8'h02, 8'h80, 8'hFF};

      // Reset state.
      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);

`ifndef MONITOR_SETTLE_EN
      // Single change: first RUN edge is E1, value enters before E3, event after E4 with ts 3.
      step(0, 1, 8'h00, 1);            // E0: IDLE -> RUN
      step(0, 1, 8'h00, 1);            // E1
      step(0, 1, 8'h00, 1);            // E2
      step(0, 1, 8'h01, 1);            // E3: in_q <= 1
      check("s1_latency", ev_valid, 1'b0);
      step(0, 1, 8'h01, 0);            // E4: push
      check("s1_valid", ev_valid, 1'b1);
      check("s1_data",  ev_data,  8'h01);
      check("s1_time",  ev_time,  16'd3);

      // Heartbeat and run budget: beats after E10/E20/E30, done from E30.
      n = 5;
      first_done = -1;
      for (int i = 0; i < 40; i++) begin
         step(0, 1, 8'h01, 1);
         if (beat) beat_edges.push_back(n);
         if (done && first_done < 0) first_done = n;
         n++;
      end
      check("s2_beat_count", beat_edges.size(), 3);
      check("s2_beat0", beat_edges.size() > 0 ? beat_edges[0] : -1, 10);
      check("s2_beat1", beat_edges.size() > 1 ? beat_edges[1] : -1, 20);
      check("s2_beat2", beat_edges.size() > 2 ? beat_edges[2] : -1, 30);
      check("s2_done_edge", first_done, 30);
      for (int i = 0; i < 5; i++) step(0, 1, W'(i + 2), 1);
      check("s2_no_event_in_done", ev_valid, 1'b0);

      // Overflow: six changes into a four-entry FIFO with no consumer.
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'h00, 0);            // E0
      for (int i = 1; i <= 6; i++) step(0, 1, W'(i * 8'h11), 0);
      step(0, 1, 8'h66, 0);
      step(0, 1, 8'h66, 0);
      check("s3_overflow", overflow, 1'b1);
      check("s3_head", ev_data, 8'h11);
      for (int i = 0; i < 6; i++) begin
         if (ev_valid) begin
            seen_val.push_back(ev_data);
            seen_ts.push_back(ev_time);
         end
         step(0, 1, 8'h66, 1);
      end
      check("s3_drain_count", seen_val.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("s3_drain_value", i < seen_val.size() ? seen_val[i] : 0, (i + 1) * 8'h11);
         if (i > 0 && i < seen_ts.size()) check("s3_ts_increasing", seen_ts[i] > seen_ts[i-1], 1'b1);
      end

      // Full FIFO: push coincides with a pop, nothing is dropped.
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'h00, 0);            // E0
      step(0, 1, 8'h11, 0);            // E1
      step(0, 1, 8'h22, 0);            // E2 push 11
      step(0, 1, 8'h33, 0);            // E3 push 22
      step(0, 1, 8'h44, 0);            // E4 push 33
      step(0, 1, 8'h55, 0);            // E5 push 44 -> full
      check("s4_full_valid", ev_valid, 1'b1);
      step(0, 1, 8'h55, 1);            // E6 push 55 + pop 11
      step(0, 1, 8'h55, 0);
      check("s4_overflow", overflow, 1'b0);
      check("s4_head", ev_data, 8'h22);

      // Enable gap: timestamps freeze for the IDLE cycles.
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'h00, 1);            // E0
      for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 1);   // E1..E4
      step(0, 1, 8'hA5, 1);            // E5
      step(0, 1, 8'hA5, 1);            // E6 push ts 5
      check("s5_time_a", ev_time, 16'd5);
      step(0, 1, 8'hA5, 1);            // E7 pop
      for (int i = 0; i < 5; i++) step(0, 0, 8'hA5, 1);   // E8..E12
      step(0, 1, 8'hA5, 1);            // E13 IDLE -> RUN
      step(0, 1, 8'h5A, 1);            // E14
      step(0, 1, 8'h5A, 1);            // E15 push ts 9
      check("s5_time_b", ev_time, 16'd9);
      for (int i = 0; i < 3; i++) step(0, 1, 8'h5A, 1);
`else
      // Settle window: a 2-cycle glitch is ignored, a 4-cycle hold is recorded.
      step(0, 1, 8'h00, 0);            // E0
      step(0, 1, 8'h00, 0);            // E1
      step(0, 1, 8'h00, 0);            // E2
      step(0, 1, 8'hFF, 0);            // E3
      step(0, 1, 8'hFF, 0);            // E4
      for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);   // E5..E7
      check("s6_glitch", ev_valid, 1'b0);
      for (int i = 0; i < 4; i++) step(0, 1, 8'hAA, 0);   // E8..E11
      check("s6_latency", ev_valid, 1'b0);
      step(0, 1, 8'hAA, 0);            // E12 push
      check("s6_valid", ev_valid, 1'b1);
      check("s6_data",  ev_data,  8'hAA);
      check("s6_time",  ev_time,  16'd8);
`endif

      // Randomized epochs against the model.
      for (int ep = 0; ep < 8; ep++) begin
         cur = 8'h00;
         step(1, 0, 8'h00, 0);
         for (int i = 0; i < 50; i++) begin
            if ($urandom_range(3) == 0) cur = pick[$urandom_range(4)];
            step(0, $urandom_range(7) != 0, cur, 1'($urandom_range(1)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
